imem_responder: RTL and testbench

Instruction-memory responder for the fetch stage's address stream. It accepts a 64-bit byte address through a valid/ready request handshake and waits a configurable number of wait states. It then returns the 32-bit instruction word through a valid/ready response handshake. A side-band load port writes the program image before or between fetches. The block sits between the fetch stage's PC register and the decode-stage instruction register.

---
 rtl/imem_responder.sv | 113 +++++++++++
 tb/tb_imem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch request, LATENCY wait states, registered response.
// Optional macro IMEM_FLUSH_EN adds a flush input that aborts an in-flight fetch.
module imem_responder #(
  parameter int          DEPTH    = 64,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [63:0]              req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [31:0]              resp_instr,
  output logic                     resp_err,
  input  logic                     resp_ready,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
`ifdef IMEM_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic [63:0] fetch_addr;
  logic        accept;
  logic        enter_resp;
  logic        flush_i;
  logic [31:0] mem [DEPTH];

`ifdef IMEM_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Misaligned or beyond the array: no wrap-around, the upper index bits must be zero.
  function automatic logic addr_bad(input logic [63:0] a);
    return (a[1:0] != 2'b00) || (a[63:IDX_W+2] != '0);
  endfunction

  assign req_ready  = reset && (state == IDLE) && !flush_i;
  assign accept     = req_ready && req_valid;
  assign resp_valid = (state == RESP);
  // With LATENCY=0 the response is registered on the accepting edge, straight from req_addr.
  assign fetch_addr = (state == IDLE) ? req_addr : addr_q;

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i && (state != IDLE)) begin
      state_nxt  = IDLE;
      enter_resp = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_instr <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(LATENCY);
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
      // Nonblocking memory write below makes this a read-before-write on a same-edge load.
      if (enter_resp) begin
        resp_err   <= addr_bad(fetch_addr);
        resp_instr <= addr_bad(fetch_addr) ? NOP_WORD : mem[fetch_addr[IDX_W+1:2]];
      end
    end
  end

  // Program image and captured address are data: retained across reset.
  always_ff @(posedge clk) begin
    if (accept)  addr_q <= req_addr;
    if (load_en) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder (DEPTH=64, LATENCY=2).
module tb_imem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        resp_err;
  logic        resp_ready;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
`ifdef IMEM_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_err(resp_err),
    .resp_ready(resp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef IMEM_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        err;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [5:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    tick();
    load_en   = 1'b0;
    load_addr = 6'h2A;
    load_data = 32'h0BAD0BAD;
  endtask

  // Accept one request, check latency and payload, optionally stall hold cycles, then pop.
  task automatic do_fetch(input string name, input logic [63:0] a, input logic [31:0] exp_i,
                          input logic exp_e, input int hold);
    int n;
    logic [31:0] first_i;
    check({name, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = (hold == 0);
    tick();
    req_valid = 1'b0;
    req_addr  = 64'hFFFF_0000_DEAD_BEE3;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    // n edges after acceptance: valid is then seen by the consumer at edge E+LAT+1.
    check({name, "_latency"}, 64'(n), 64'(LAT));
    if (!resp_valid) return;
    check({name, "_instr"}, 64'(resp_instr), 64'(exp_i));
    check({name, "_err"}, 64'(resp_err), 64'(exp_e));
    check({name, "_busy"}, 64'(req_ready), 64'd0);
    first_i = resp_instr;
    for (int k = 0; k < hold; k++) begin
      tick();
      check({name, "_hold"}, {30'd0, resp_valid, req_ready, resp_instr}, {30'd0, 1'b1, 1'b0, first_i});
    end
    resp_ready = 1'b1;
    if (hold != 0) tick();
    else if (n == 0) tick();
    else tick();
    resp_ready = 1'b0;
    check({name, "_pop"}, {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
`ifdef IMEM_FLUSH_EN
    flush      = 1'b0;
`endif

    vecs[0] = '{addr: 64'h0,                   instr: 32'h8B020020, err: 1'b0, hold: 0};
    vecs[1] = '{addr: 64'h4,                   instr: 32'hF8400041, err: 1'b0, hold: 5};
    vecs[2] = '{addr: 64'h6,                   instr: NOP,          err: 1'b1, hold: 0};
    vecs[3] = '{addr: 64'h100,                 instr: NOP,          err: 1'b1, hold: 0};
    vecs[4] = '{addr: 64'hFC,                  instr: 32'h12345678, err: 1'b0, hold: 1};
    vecs[5] = '{addr: 64'h8000_0000_0000_0000, instr: NOP,          err: 1'b1, hold: 0};
    vecs[6] = '{addr: 64'h1,                   instr: NOP,          err: 1'b1, hold: 0};
    vecs[7] = '{addr: 64'h8,                   instr: 32'h00C0FFEE, err: 1'b0, hold: 2};

    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp", {29'd0, resp_valid, resp_err, 1'b0, resp_instr}, 64'd0);
    reset = 1'b1;
    #1;
    check("rel_req_ready", 64'(req_ready), 64'd1);

    load_word(6'd0,  32'h8B020020);
    load_word(6'd1,  32'hF8400041);
    load_word(6'd2,  32'h00C0FFEE);
    load_word(6'd63, 32'h12345678);

    foreach (vecs[i])
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err, vecs[i].hold);

    // Same-word load on the RESP-entry edge: old word is returned.
    req_valid = 1'b1;
    req_addr  = 64'h0;
    tick();
    req_valid = 1'b0;
    tick();
    load_en   = 1'b1;
    load_addr = 6'd0;
    load_data = 32'hAAAA5555;
    tick();
    load_en = 1'b0;
    check("rbw_valid", 64'(resp_valid), 64'd1);
    check("rbw_instr", 64'(resp_instr), 64'h8B020020);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    do_fetch("rbw_after", 64'h0, 32'hAAAA5555, 1'b0, 0);

    // Reset during WAIT abandons the fetch.
    req_valid = 1'b1;
    req_addr  = 64'h4;
    tick();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_rel_ready", 64'(req_ready), 64'd1);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (resp_valid) n++;
    end
    check("mid_rst_no_resp", 64'(n), 64'd0);
    resp_ready = 1'b0;
    do_fetch("mid_rst_mem", 64'h4, 32'hF8400041, 1'b0, 0);

`ifdef IMEM_FLUSH_EN
    // Flush during WAIT drops the request.
    req_valid = 1'b1;
    req_addr  = 64'h0;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_wait_idle", {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (resp_valid) n++;
    end
    check("flush_wait_no_resp", 64'(n), 64'd0);
    // Flush in IDLE blocks acceptance.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 64'h4;
    #1;
    check("flush_idle_ready", 64'(req_ready), 64'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle_not_taken", 64'(req_ready), 64'd1);
    // Flush in RESP wins over resp_ready.
    req_valid = 1'b1;
    req_addr  = 64'h8;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("flush_resp_valid", 64'(resp_valid), 64'd1);
    flush      = 1'b1;
    resp_ready = 1'b1;
    tick();
    flush      = 1'b0;
    resp_ready = 1'b0;
    check("flush_resp_drop", {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
    do_fetch("flush_next", 64'h4, 32'hF8400041, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
